// File: rtl/pipe_delay.sv
// Fixed-latency delay line: val_in re-emerges on val_out after exactly STAGES clock edges.
// Every stage is tapped onto pipe_out, with stage 0 in the least significant bits.
module pipe_delay #(
  parameter int STAGES = 1,
  parameter int WIDTH  = 1
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [WIDTH-1:0]                                val_in,
  output logic [WIDTH-1:0]                                val_out,
  input  logic [WIDTH-1:0]                                pipe_in,
  output logic [((STAGES == 0) ? WIDTH : WIDTH*STAGES)-1:0] pipe_out
);

  // pipe_in is a reserved cascade hook; folding it into an unused net keeps it inert.
  logic unused_pipe_in;
  assign unused_pipe_in = ^pipe_in;

  if (STAGES == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset;
    assign val_out     = val_in;
    assign pipe_out    = val_in;
  end else begin : g_regs
    // The initializer gives all-zero power-up contents before the first reset.
    logic [WIDTH*STAGES-1:0] stage_q = '0;

    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) stage_q <= '0;
        else       stage_q <= val_in;
      end
    end else begin : g_chain
      // Shift towards the MSBs so that the newest sample always sits in stage 0.
      always_ff @(posedge clk) begin
        if (reset) stage_q <= '0;
        else       stage_q <= {stage_q[WIDTH*(STAGES-1)-1:0], val_in};
      end
    end

    assign val_out  = stage_q[WIDTH*STAGES-1 -: WIDTH];
    assign pipe_out = stage_q;
  end

endmodule

// File: tb/tb_pipe_delay.sv
// Directed checks of pipe_delay: the main 4x2 instance, a pipe_in isolation copy,
// and the degenerate sizes (0 stages, 1 stage, 1-bit x 6 stages).
module tb_pipe_delay;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] val_in = 2'b00;
  logic [1:0] iso_pipe_in = 2'b00;
  logic       bit_in = 1'b0;

  logic [1:0] main_out, iso_out, d0_out, d0_pipe, d1_out, d1_pipe;
  logic [7:0] main_pipe, iso_pipe;
  logic       d6_out;
  logic [5:0] d6_pipe;

  int checks = 0;
  int errors = 0;
  logic [1:0] d1_exp = 2'b00;
  logic       bits [1000];
  logic [1:0] seq [16];

  always #5 clk = ~clk;

  pipe_delay #(.STAGES(4), .WIDTH(2)) dut (
    .clk(clk), .reset(reset), .val_in(val_in), .val_out(main_out),
    .pipe_in(2'b00), .pipe_out(main_pipe));

  pipe_delay #(.STAGES(4), .WIDTH(2)) dut_iso (
    .clk(clk), .reset(reset), .val_in(val_in), .val_out(iso_out),
    .pipe_in(iso_pipe_in), .pipe_out(iso_pipe));

  pipe_delay #(.STAGES(0), .WIDTH(2)) dut_s0 (
    .clk(clk), .reset(reset), .val_in(val_in), .val_out(d0_out),
    .pipe_in(2'b00), .pipe_out(d0_pipe));

  pipe_delay #(.STAGES(1), .WIDTH(2)) dut_s1 (
    .clk(clk), .reset(reset), .val_in(val_in), .val_out(d1_out),
    .pipe_in(2'b00), .pipe_out(d1_pipe));

  pipe_delay #(.STAGES(6), .WIDTH(1)) dut_w1 (
    .clk(clk), .reset(reset), .val_in(bit_in), .val_out(d6_out),
    .pipe_in(1'bz), .pipe_out(d6_pipe));

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Both 4-stage instances must agree with the same hand-computed values.
  task automatic checkMain(input string tag, input logic [1:0] exp_val,
                           input logic [7:0] exp_pipe);
    checkOutput({tag, " val_out"}, {6'b0, main_out}, {6'b0, exp_val});
    checkOutput({tag, " pipe_out"}, main_pipe, exp_pipe);
    checkOutput({tag, " iso val_out"}, {6'b0, iso_out}, {6'b0, exp_val});
    checkOutput({tag, " iso pipe_out"}, iso_pipe, exp_pipe);
  endtask

  // Drive one cycle's inputs mid-period, then sample #1 after the rising edge.
  task automatic applyStimulus(input logic [1:0] v, input logic r, input logic b);
    @(negedge clk);
    val_in = v;
    reset  = r;
    bit_in = b;
    case ($urandom_range(3, 0))
      0:       iso_pipe_in = 2'bxx;
      1:       iso_pipe_in = 2'bzz;
      default: iso_pipe_in = 2'($urandom);
    endcase
    #1;
    checkOutput("s0 passthrough val_out", {6'b0, d0_out}, {6'b0, v});
    checkOutput("s0 passthrough pipe_out", {6'b0, d0_pipe}, {6'b0, v});
    @(posedge clk);
    #1;
    d1_exp = r ? 2'b00 : v;
    checkOutput("s1 val_out", {6'b0, d1_out}, {6'b0, d1_exp});
    checkOutput("s1 pipe_out", {6'b0, d1_pipe}, {6'b0, d1_exp});
  endtask

  initial begin
    logic [7:0] exp_pipe;
    logic [5:0] exp6;

    #1;
    checkMain("powerup", 2'b00, 8'h00);
    checkOutput("powerup s1", {6'b0, d1_out}, 8'h00);
    checkOutput("powerup w1", {7'b0, d6_out}, 8'h00);

    // Single pulse after two reset cycles
    applyStimulus(2'b00, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkMain("reset", 2'b00, 8'h00);
    applyStimulus(2'b01, 1'b0, 1'b0); checkMain("pulse e0", 2'b00, 8'b00000001);
    applyStimulus(2'b00, 1'b0, 1'b0); checkMain("pulse e1", 2'b00, 8'b00000100);
    applyStimulus(2'b00, 1'b0, 1'b0); checkMain("pulse e2", 2'b00, 8'b00010000);
    applyStimulus(2'b00, 1'b0, 1'b0); checkMain("pulse e3", 2'b01, 8'b01000000);
    applyStimulus(2'b00, 1'b0, 1'b0); checkMain("pulse e4", 2'b00, 8'b00000000);
    applyStimulus(2'b00, 1'b0, 1'b0); checkMain("pulse e5", 2'b00, 8'b00000000);

    // Streaming 0,1,2,3,... behind an all-zero pipeline
    for (int i = 0; i < 12; i++) begin
      seq[i] = 2'(i % 4);
      applyStimulus(seq[i], 1'b0, 1'b0);
      exp_pipe = 8'h00;
      for (int k = 0; k < 4; k++)
        if (i - k >= 0) exp_pipe[2*k +: 2] = seq[i-k];
      checkMain($sformatf("stream %0d", i), (i >= 3) ? seq[i-3] : 2'b00, exp_pipe);
    end

    // Mid-flight reset flushes 3,2,1 and older data
    applyStimulus(2'b11, 1'b0, 1'b0); checkMain("flush in3", 2'b01, 8'b01101111);
    applyStimulus(2'b10, 1'b0, 1'b0); checkMain("flush in2", 2'b10, 8'b10111110);
    applyStimulus(2'b01, 1'b0, 1'b0); checkMain("flush in1", 2'b11, 8'b11111001);
    applyStimulus(2'b11, 1'b1, 1'b0); checkMain("flush rst", 2'b00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkMain($sformatf("flush quiet %0d", i), 2'b00, 8'h00);
    end
    applyStimulus(2'b10, 1'b0, 1'b0); checkMain("after flush e0", 2'b00, 8'b00000010);
    applyStimulus(2'b00, 1'b0, 1'b0); checkMain("after flush e1", 2'b00, 8'b00001000);
    applyStimulus(2'b00, 1'b0, 1'b0); checkMain("after flush e2", 2'b00, 8'b00100000);
    applyStimulus(2'b00, 1'b0, 1'b0); checkMain("after flush e3", 2'b10, 8'b10000000);
    applyStimulus(2'b00, 1'b0, 1'b0); checkMain("after flush e4", 2'b00, 8'h00);

    // Reset dominates val_in held at 3
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0);
      checkMain($sformatf("hold rst %0d", i), 2'b00, 8'h00);
    end
    applyStimulus(2'b11, 1'b0, 1'b0); checkMain("release e0", 2'b00, 8'b00000011);
    applyStimulus(2'b11, 1'b0, 1'b0); checkMain("release e1", 2'b00, 8'b00001111);
    applyStimulus(2'b11, 1'b0, 1'b0); checkMain("release e2", 2'b00, 8'b00111111);
    applyStimulus(2'b11, 1'b0, 1'b0); checkMain("release e3", 2'b11, 8'b11111111);

    // 1-bit, 6-stage random stream
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("w1 reset", {2'b0, d6_pipe}, 8'h00);
    for (int i = 0; i < 1000; i++) begin
      bits[i] = 1'($urandom);
      applyStimulus(2'b00, 1'b0, bits[i]);
      exp6 = 6'b0;
      for (int k = 0; k < 6; k++)
        if (i - k >= 0) exp6[k] = bits[i-k];
      checkOutput($sformatf("w1 val_out %0d", i), {7'b0, d6_out},
                  {7'b0, (i >= 5) ? bits[i-5] : 1'b0});
      checkOutput($sformatf("w1 pipe_out %0d", i), {2'b0, d6_pipe}, {2'b0, exp6});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
